// File: rtl/pool_window_feeder.sv
// Feeds 2x4 pixel windows to the pooler: buffers each even row, then pairs it with
// the following odd row and emits one 8-word group for every 4 odd-row pixels.
module pool_window_feeder #(
    parameter int DW    = 16,
    parameter int MAX_W = 28
) (
    input  logic          clk,
    input  logic          rst_fsm,
    input  logic          cfg_start,
    input  logic [4:0]    cfg_width,
    input  logic [4:0]    cfg_height,
    output logic          cfg_err,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          start,
    output logic          en,
    output logic          done,
    output logic [4:0]    size_1,
    output logic [4:0]    size_2,
    output logic [DW-1:0] d_0,
    output logic [DW-1:0] d_1,
    output logic [DW-1:0] d_2,
    output logic [DW-1:0] d_3,
    output logic [DW-1:0] d_4,
    output logic [DW-1:0] d_5,
    output logic [DW-1:0] d_6,
    output logic [DW-1:0] d_7
);

    typedef enum logic [1:0] {
        IDLE,
        ROW_EVEN,
        ROW_ODD
    } state_t;

    state_t state, state_nxt;

    logic [4:0]    col;
    logic [4:0]    row;
    logic [4:0]    grp_base;
    logic [DW-1:0] linebuf [0:MAX_W-1];
    logic [DW-1:0] sr_0, sr_1, sr_2;

    logic cfg_legal;
    logic cfg_take;
    logic accept;
    logic last_col;
    logic last_row;
    logic group_end;

    assign cfg_legal = (cfg_width[1:0] == 2'b00) && (cfg_width != '0) &&
                       (32'(cfg_width) <= MAX_W) &&
                       (cfg_height[0] == 1'b0) && (cfg_height != '0);
    assign cfg_take  = (state == IDLE) && cfg_start && cfg_legal;
    assign s_ready   = (state != IDLE);
    assign accept    = s_valid && s_ready;
    assign last_col  = (col == size_1 - 5'd1);
    assign last_row  = (row == size_2 - 5'd1);
    assign group_end = accept && (state == ROW_ODD) && (col[1:0] == 2'b11);
    assign grp_base  = {col[4:2], 2'b00};

    always_ff @(posedge clk or posedge rst_fsm) begin
        if (rst_fsm) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cfg_take) state_nxt = ROW_EVEN;
            ROW_EVEN: if (accept && last_col) state_nxt = ROW_ODD;
            ROW_ODD:  if (accept && last_col) state_nxt = last_row ? IDLE : ROW_EVEN;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_fsm) begin
        if (rst_fsm) begin
            cfg_err <= 1'b0;
            start   <= 1'b0;
            en      <= 1'b0;
            done    <= 1'b0;
            size_1  <= '0;
            size_2  <= '0;
            col     <= '0;
            row     <= '0;
            sr_0    <= '0;
            sr_1    <= '0;
            sr_2    <= '0;
            d_0     <= '0;
            d_1     <= '0;
            d_2     <= '0;
            d_3     <= '0;
            d_4     <= '0;
            d_5     <= '0;
            d_6     <= '0;
            d_7     <= '0;
        end else begin
            cfg_err <= (state == IDLE) && cfg_start && !cfg_legal;
            start   <= cfg_take;
            en      <= group_end;
            done    <= group_end && last_col && last_row;

            if (cfg_take) begin
                size_1 <= cfg_width;
                size_2 <= cfg_height;
                col    <= '0;
                row    <= '0;
            end else if (accept) begin
                if (last_col) begin
                    col <= '0;
                    row <= row + 5'd1;
                end else begin
                    col <= col + 5'd1;
                end
            end

            if (accept && (state == ROW_ODD)) begin
                sr_0 <= sr_1;
                sr_1 <= sr_2;
                sr_2 <= s_data;
            end

            // The 4th pixel bypasses the shift register so the group leaves one cycle after it.
            if (group_end) begin
                d_0 <= linebuf[grp_base];
                d_1 <= linebuf[grp_base + 5'd1];
                d_2 <= linebuf[grp_base + 5'd2];
                d_3 <= linebuf[grp_base + 5'd3];
                d_4 <= sr_0;
                d_5 <= sr_1;
                d_6 <= sr_2;
                d_7 <= s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept && (state == ROW_EVEN)) begin
            linebuf[col] <= s_data;
        end
    end

endmodule

// File: tb/tb_pool_window_feeder.sv
// Self-checking bench for pool_window_feeder: frame-level reference model of the
// expected 2x4 windows, with random data and random s_valid gaps.
module tb_pool_window_feeder;

    localparam int DW    = 16;
    localparam int MAX_W = 28;

    logic          clk = 1'b0;
    logic          rst_fsm;
    logic          cfg_start;
    logic [4:0]    cfg_width;
    logic [4:0]    cfg_height;
    logic          cfg_err;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          start;
    logic          en;
    logic          done;
    logic [4:0]    size_1;
    logic [4:0]    size_2;
    logic [DW-1:0] d_0, d_1, d_2, d_3, d_4, d_5, d_6, d_7;

    logic [DW-1:0] d_arr  [0:7];
    logic [DW-1:0] last_d [0:7];
    logic [DW-1:0] px     [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    pool_window_feeder #(.DW(DW), .MAX_W(MAX_W)) dut (
        .clk        (clk),
        .rst_fsm    (rst_fsm),
        .cfg_start  (cfg_start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .cfg_err    (cfg_err),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .start      (start),
        .en         (en),
        .done       (done),
        .size_1     (size_1),
        .size_2     (size_2),
        .d_0        (d_0),
        .d_1        (d_1),
        .d_2        (d_2),
        .d_3        (d_3),
        .d_4        (d_4),
        .d_5        (d_5),
        .d_6        (d_6),
        .d_7        (d_7)
    );

    assign d_arr[0] = d_0;
    assign d_arr[1] = d_1;
    assign d_arr[2] = d_2;
    assign d_arr[3] = d_3;
    assign d_arr[4] = d_4;
    assign d_arr[5] = d_5;
    assign d_arr[6] = d_6;
    assign d_arr[7] = d_7;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_s_ready"}, 32'(s_ready), 0);
        check({tag, "_cfg_err"}, 32'(cfg_err), 0);
        check({tag, "_start"},   32'(start), 0);
        check({tag, "_en"},      32'(en), 0);
        check({tag, "_done"},    32'(done), 0);
        check({tag, "_size_1"},  32'(size_1), 0);
        check({tag, "_size_2"},  32'(size_2), 0);
        for (int k = 0; k < 8; k++) begin
            check({tag, "_d"}, 32'(d_arr[k]), 0);
            last_d[k] = '0;
        end
    endtask

    // Drives one full frame and compares every output cycle against the window model.
    task automatic run_frame(input int w, input int h, input bit rnd, input int base,
                             input int gap, input bit poke);
        int  total, g, idx, cyc, p, gpr, r, j, col;
        bit  rdy, v, acc, exp_en;
        for (int i = 0; i < w * h; i++) px[i] = rnd ? DW'($urandom) : DW'(base + i);
        cfg_width  = 5'(w);
        cfg_height = 5'(h);
        cfg_start  = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        check("start_pulse", 32'(start), 1);
        check("size_1", 32'(size_1), 32'(w));
        check("size_2", 32'(size_2), 32'(h));
        check("cfg_err_legal", 32'(cfg_err), 0);
        total = (w / 4) * (h / 2);
        gpr   = w / 4;
        g = 0; idx = 0; cyc = 0;
        while (g < total && cyc < w * h * 20 + 100) begin
            rdy     = s_ready;
            v       = (idx < w * h) && ($urandom_range(0, 99) >= gap);
            s_valid = v;
            s_data  = v ? px[idx] : DW'($urandom);
            if (poke && idx == w + 1) begin
                cfg_start  = 1'b1;
                cfg_width  = 5'd4;
                cfg_height = 5'd2;
            end else begin
                cfg_start = 1'b0;
            end
            @(posedge clk);
            acc    = v && rdy;
            exp_en = 1'b0;
            if (acc) begin
                p      = idx;
                idx++;
                exp_en = ((p / w) % 2 == 1) && ((p % w) % 4 == 3);
            end
            #1;
            cyc++;
            check("start_low", 32'(start), 0);
            check("cfg_err_low", 32'(cfg_err), 0);
            check("en", 32'(en), 32'(exp_en));
            if (exp_en) begin
                r = g / gpr;
                j = g % gpr;
                for (int k = 0; k < 4; k++) begin
                    col = 4 * j + k;
                    check("d_even_row", 32'(d_arr[k]),     32'(px[(2 * r) * w + col]));
                    check("d_odd_row",  32'(d_arr[k + 4]), 32'(px[(2 * r + 1) * w + col]));
                end
                check("done", 32'(done), 32'(g == total - 1));
                for (int k = 0; k < 4; k++) begin
                    last_d[k]     = px[(2 * r) * w + 4 * j + k];
                    last_d[k + 4] = px[(2 * r + 1) * w + 4 * j + k];
                end
                g++;
            end else begin
                check("done_no_en", 32'(done), 0);
                for (int k = 0; k < 8; k++) check("d_hold", 32'(d_arr[k]), 32'(last_d[k]));
            end
        end
        cfg_start = 1'b0;
        s_valid   = 1'b0;
        check("group_count", 32'(g), 32'(total));
        check("pixels_taken", 32'(idx), 32'(w * h));
        check("s_ready_idle", 32'(s_ready), 0);
        check("size_1_kept", 32'(size_1), 32'(w));
        check("size_2_kept", 32'(size_2), 32'(h));
    endtask

    task automatic cfg_bad(input int w, input int h);
        logic [4:0] sz1, sz2;
        sz1        = size_1;
        sz2        = size_2;
        cfg_width  = 5'(w);
        cfg_height = 5'(h);
        cfg_start  = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        check("bad_cfg_err", 32'(cfg_err), 1);
        check("bad_s_ready", 32'(s_ready), 0);
        check("bad_start", 32'(start), 0);
        check("bad_size_1", 32'(size_1), 32'(sz1));
        check("bad_size_2", 32'(size_2), 32'(sz2));
        @(posedge clk);
        #1;
        check("bad_cfg_err_clear", 32'(cfg_err), 0);
        check("bad_s_ready_later", 32'(s_ready), 0);
        check("bad_start_later", 32'(start), 0);
    endtask

    initial begin
        rst_fsm    = 1'b1;
        cfg_start  = 1'b0;
        cfg_width  = '0;
        cfg_height = '0;
        s_valid    = 1'b0;
        s_data     = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst_fsm = 1'b0;
        @(posedge clk);
        #1;

        // Smallest frame: pixels 1..8, continuous valid.
        run_frame(4, 2, 1'b0, 1, 0, 1'b0);
        // 8x4 frame with data 0..31 and random gaps.
        run_frame(8, 4, 1'b0, 0, 40, 1'b0);

        // Illegal configurations.
        cfg_bad(6, 2);
        cfg_bad(4, 3);
        cfg_bad(0, 2);
        cfg_bad(31, 2);
        cfg_bad(4, 0);

        // Asynchronous reset after 10 pixels of an 8x4 frame.
        cfg_width  = 5'd8;
        cfg_height = 5'd4;
        cfg_start  = 1'b1;
        @(posedge clk);
        #1;
        cfg_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            s_valid = 1'b1;
            s_data  = DW'(100 + i);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        #2;
        rst_fsm = 1'b1;
        #1;
        check_all_zero("async_reset");
        @(posedge clk);
        #1;
        check("reset_no_done", 32'(done), 0);
        rst_fsm = 1'b0;
        run_frame(8, 4, 1'b1, 0, 20, 1'b0);

        // Mid-frame cfg_start ignored, then a back-to-back frame.
        run_frame(8, 4, 1'b0, 0, 40, 1'b1);
        run_frame(4, 2, 1'b1, 0, 10, 1'b0);

        // Random legal frames.
        for (int f = 0; f < 4; f++) begin
            run_frame(4 * $urandom_range(1, MAX_W / 4), 2 * $urandom_range(1, 15),
                      1'b1, 0, 30, 1'b0);
        end

        // Largest frame, incrementing data.
        run_frame(28, 30, 1'b0, 0, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
